// File: rtl/vector_seq_pkg.sv
// Shared types and helpers for the vector iteration sequencer.
package vector_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2,
    FIN  = 2'd3
  } seq_state_e;

  // Number of PARALLELISM-wide beats needed to cover one vector.
  function automatic int unsigned beats_f(input int unsigned length,
                                          input int unsigned parallelism);
    return length / parallelism;
  endfunction

endpackage

// File: rtl/vector_iter_sequencer_if.sv
// Control, buffer-port and compute-lane signals of the vector iteration sequencer.
interface vector_iter_sequencer_if #(
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5
);
  logic                              start;
  logic [15:0]                       num_iters;
  logic                              busy;
  logic                              done;
  logic [15:0]                       iter_count;
  logic                              ping;
  logic                              x_valid;
  logic                              x_ready;
  logic [PARALLELISM*ADDR_WIDTH-1:0] x_addr;
  logic                              x_rvalid;
  logic [PARALLELISM*DATA_WIDTH-1:0] x_rdata;
  logic                              x_rready;
  logic                              cmp_valid;
  logic [PARALLELISM*DATA_WIDTH-1:0] cmp_data;
  logic                              cmp_ready;
  logic                              res_valid;
  logic [PARALLELISM*DATA_WIDTH-1:0] res_data;
  logic                              res_ready;
  logic                              xn_valid;
  logic                              xn_ready;
  logic [PARALLELISM*ADDR_WIDTH-1:0] xn_addr;
  logic [PARALLELISM*DATA_WIDTH-1:0] xn_wdata;

  modport master (
    input  start, num_iters, x_ready, x_rvalid, x_rdata, cmp_ready,
           res_valid, res_data, xn_ready,
    output busy, done, iter_count, ping, x_valid, x_addr, x_rready,
           cmp_valid, cmp_data, res_ready, xn_valid, xn_addr, xn_wdata
  );

  modport slave (
    output start, num_iters, x_ready, x_rvalid, x_rdata, cmp_ready,
           res_valid, res_data, xn_ready,
    input  busy, done, iter_count, ping, x_valid, x_addr, x_rready,
           cmp_valid, cmp_data, res_ready, xn_valid, xn_addr, xn_wdata
  );

endinterface

// File: rtl/vector_addr_gen.sv
// Saturating beat counter with per-lane element address expansion.
module vector_addr_gen
  import vector_seq_pkg::*;
#(
  parameter  int unsigned LENGTH      = 32,
  parameter  int unsigned PARALLELISM = 4,
  localparam int unsigned BEATS       = beats_f(LENGTH, PARALLELISM),
  localparam int unsigned AW          = $clog2(LENGTH),
  localparam int unsigned BW          = $clog2(BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      inc,
  output logic [BW-1:0]             beat,
  output logic                      full,
  output logic [PARALLELISM*AW-1:0] addr
);

  assign full = (beat == BW'(BEATS));

  // Beat counter: cleared between iterations, stops at BEATS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (clr) begin
      beat <= '0;
    end else if (inc && !full) begin
      beat <= beat + BW'(1);
    end
  end

  // Lane i of the current beat addresses element beat*PARALLELISM + i.
  always_comb begin
    addr = '0;
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      addr[i*AW +: AW] = AW'(32'(beat) * PARALLELISM + i);
    end
  end

endmodule

// File: rtl/vector_iter_sequencer.sv
// Streams x through the compute lane into x_n, swapping buffers once per iteration.
module vector_iter_sequencer
  import vector_seq_pkg::*;
#(
  parameter int unsigned LENGTH          = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PARALLELISM     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  vector_iter_sequencer_if.master bus
);

  localparam int unsigned BEATS      = beats_f(LENGTH, PARALLELISM);
  localparam int unsigned ADDR_WIDTH = $clog2(LENGTH);
  localparam int unsigned BEAT_W     = $clog2(BEATS + 1);
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BUS_W      = PARALLELISM * DATA_WIDTH;

  if (LENGTH % PARALLELISM != 0) begin : g_len_chk
    $error("LENGTH must be a multiple of PARALLELISM");
  end
  if (MAX_OUTSTANDING < 1) begin : g_out_chk
    $error("MAX_OUTSTANDING must be at least 1");
  end

  seq_state_e                       state, state_nxt;
  logic [15:0]                      num_iters_q, iter_count_q;
  logic [OUT_W-1:0]                 outstanding;
  logic [BEAT_W-1:0]                rd_beat, wr_beat;
  logic                             rd_full, wr_full;
  logic [PARALLELISM*ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [BUS_W-1:0]                 rdata, wdata;
  logic                             in_run, x_valid_c, rd_hs, wr_hs, wr_last, cnt_clr;
  logic                             unused;

  assign in_run    = (state == RUN);
  assign x_valid_c = in_run && !rd_full && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign rd_hs     = x_valid_c && bus.x_ready;
  assign wr_hs     = in_run && bus.res_valid && bus.xn_ready;
  assign wr_last   = (wr_beat == BEAT_W'(BEATS - 1));
  assign cnt_clr   = !in_run;
  assign unused    = ^{rd_beat, wr_full};

  vector_addr_gen #(.LENGTH(LENGTH), .PARALLELISM(PARALLELISM)) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(rd_hs),
    .beat(rd_beat), .full(rd_full), .addr(rd_addr)
  );

  vector_addr_gen #(.LENGTH(LENGTH), .PARALLELISM(PARALLELISM)) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(wr_hs),
    .beat(wr_beat), .full(wr_full), .addr(wr_addr)
  );

  // Data paths are pure pass-through; the lane and buffer do the buffering.
  assign rdata         = bus.x_rdata;
  assign wdata         = bus.res_data;
  assign bus.cmp_data  = rdata;
  assign bus.xn_wdata  = wdata;
  assign bus.cmp_valid = bus.x_rvalid;
  assign bus.x_rready  = bus.cmp_ready;
  assign bus.x_valid   = x_valid_c;
  assign bus.x_addr    = rd_addr;
  assign bus.xn_valid  = in_run && bus.res_valid;
  assign bus.res_ready = in_run && bus.xn_ready;
  assign bus.xn_addr   = wr_addr;
  assign bus.iter_count = iter_count_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.ping  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.num_iters != 16'd0) ? RUN : FIN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (wr_hs && wr_last) state_nxt = SWAP;
      end
      SWAP: begin
        bus.busy  = 1'b1;
        bus.ping  = 1'b1;
        state_nxt = (iter_count_q + 16'd1 == num_iters_q) ? FIN : RUN;
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run parameters latched on an accepted start; iteration tally bumps on each swap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_iters_q  <= '0;
      iter_count_q <= '0;
    end else if (state == IDLE && bus.start) begin
      num_iters_q  <= bus.num_iters;
      iter_count_q <= '0;
    end else if (state == SWAP) begin
      iter_count_q <= iter_count_q + 16'd1;
    end
  end

  // Beats read-accepted but not yet written; cleared outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      outstanding <= '0;
    end else if (rd_hs && !wr_hs) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (wr_hs && !rd_hs && outstanding != '0) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule
